// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS-I encodings for the MEM/WB boundary.
// Contents:
//   - Datapath widths and the default jal link register.
//   - Opcode and funct encodings used by writeback decode.
//   - The load_kind_e classification and the load_kind/is_load helpers.
package mips_pkg;

    localparam int          DW_DEF   = 32;
    localparam int          RA_W_DEF = 5;
    localparam logic [4:0]  LINK_R_DEF = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;

    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        LD_NONE,
        LD_B,
        LD_BU,
        LD_H,
        LD_HU,
        LD_W
    } load_kind_e;

    function automatic load_kind_e load_kind(input logic [5:0] op);
        load_kind_e k;
        case (op)
            OP_LB:   k = LD_B;
            OP_LBU:  k = LD_BU;
            OP_LH:   k = LD_H;
            OP_LHU:  k = LD_HU;
            OP_LW:   k = LD_W;
            default: k = LD_NONE;
        endcase
        return k;
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return load_kind(op) != LD_NONE;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational big-endian lane select and extension of a
// data-memory word for the MIPS-I load family.
// Ports:
//   word_i        [31:0]  raw memory word
//   addr_i        [1:0]   low address bits of the load
//   op_i          [5:0]   load opcode (non-loads produce 0 / no flag)
//   data_o        [31:0]  aligned, extended load value
//   misaligned_o          half with addr[0]=1 or word with addr!=0
module mem_load_align
    import mips_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [5:0]  op_i,
    output logic [31:0] data_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    load_kind_e  kind;

    always_comb begin
        kind = load_kind(op_i);

        // Big-endian lanes: address 0 is the most significant byte.
        case (addr_i)
            2'd0:    byte_sel = word_i[31:24];
            2'd1:    byte_sel = word_i[23:16];
            2'd2:    byte_sel = word_i[15:8];
            default: byte_sel = word_i[7:0];
        endcase

        half_sel = addr_i[1] ? word_i[15:0] : word_i[31:16];

        data_o       = 32'd0;
        misaligned_o = 1'b0;
        case (kind)
            LD_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU: data_o = {24'd0, byte_sel};
            LD_H: begin
                data_o       = {{16{half_sel[15]}}, half_sel};
                misaligned_o = addr_i[0];
            end
            LD_HU: begin
                data_o       = {16'd0, half_sel};
                misaligned_o = addr_i[0];
            end
            LD_W: begin
                data_o       = word_i;
                misaligned_o = (addr_i != 2'd0);
            end
            default: begin
                data_o       = 32'd0;
                misaligned_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline boundary of a 5-stage MIPS-I core.
// Captures the EX/MEM slot, aligns load data returned one cycle later by
// data memory, and drives the register-file write port.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid              EX/MEM slot holds a real instruction
//   in_instruction [31:0] instruction in the EX/MEM slot
//   in_alu_result  [31:0] ALU result / load address / jal link value
//   mem_read_data  [31:0] data-memory word, valid the cycle after capture
//   stall, flush          hold the stage / kill the captured instruction
//   wb_valid              stage holds a live instruction
//   wb_reg_write          register-file write enable
//   wb_write_reg           destination register
//   wb_write_data          writeback data
//   wb_misaligned          live load with a misaligned address
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int         DW     = DW_DEF,
    parameter int         RA_W   = RA_W_DEF,
    parameter logic [4:0] LINK_R = LINK_R_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_instruction,
    input  logic [DW-1:0]   in_alu_result,
    input  logic [DW-1:0]   mem_read_data,
    input  logic            stall,
    input  logic            flush,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [RA_W-1:0] wb_write_reg,
    output logic [DW-1:0]   wb_write_data,
    output logic            wb_misaligned
);

    logic          valid_q,      valid_d;
    logic [31:0]   instr_q,      instr_d;
    logic [31:0]   alu_q,        alu_d;
    logic          hold_valid_q, hold_valid_d;
    logic [31:0]   hold_data_q,  hold_data_d;

    logic [5:0]    op;
    logic [5:0]    funct;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          writes;
    logic          use_load;
    logic [4:0]    dest;
    logic [31:0]   load_word;
    logic [31:0]   load_data;
    logic          load_mis;
    logic          unused_bits;

    assign op          = instr_q[31:26];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign funct       = instr_q[5:0];
    assign unused_bits = ^{instr_q[25:21], instr_q[10:6]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            instr_q      <= 32'd0;
            alu_q        <= 32'd0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 32'd0;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            alu_q        <= alu_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        alu_d   = alu_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
            instr_d = in_instruction;
            alu_d   = in_alu_result;
        end

        // Memory only returns the word for one cycle; park it on the first
        // stalled edge so the eventual writeback sees the original value.
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (!stall || flush) begin
            hold_valid_d = 1'b0;
        end else if (valid_q && is_load(op) && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_data_d  = mem_read_data;
        end
    end

    assign load_word = hold_valid_q ? hold_data_q : mem_read_data;

    mem_load_align u_align (
        .word_i       (load_word),
        .addr_i       (alu_q[1:0]),
        .op_i         (op),
        .data_o       (load_data),
        .misaligned_o (load_mis)
    );

    always_comb begin
        writes   = 1'b0;
        use_load = 1'b0;
        dest     = 5'd0;
        case (op)
            OP_RTYPE: begin
                writes = (funct != FN_JR);
                dest   = rd;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                writes = 1'b1;
                dest   = rt;
            end
            OP_JAL: begin
                writes = 1'b1;
                dest   = LINK_R;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                writes   = 1'b1;
                use_load = 1'b1;
                dest     = rt;
            end
            default: begin
                writes = 1'b0;
                dest   = 5'd0;
            end
        endcase
    end

    always_comb begin
        wb_valid      = valid_q;
        wb_reg_write  = valid_q && writes && (dest != 5'd0) && !stall;
        wb_write_reg  = '0;
        wb_write_data = '0;
        if (valid_q && writes) begin
            wb_write_reg  = RA_W'(dest);
            wb_write_data = DW'(use_load ? load_data : alu_q);
        end
        wb_misaligned = valid_q && use_load && load_mis;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instruction;
    logic [31:0] in_alu_result;
    logic [31:0] mem_read_data;
    logic        stall;
    logic        flush;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        wb_misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_instruction (in_instruction),
        .in_alu_result  (in_alu_result),
        .mem_read_data  (mem_read_data),
        .stall          (stall),
        .flush          (flush),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_write_reg   (wb_write_reg),
        .wb_write_data  (wb_write_data),
        .wb_misaligned  (wb_misaligned)
    );

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [15:0] imm);
        return {op, 5'd3, rt, imm};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                         input logic st, input logic fl);
        in_valid       = v;
        in_instruction = ins;
        in_alu_result  = alu;
        stall          = st;
        flush          = fl;
    endtask

    // Advance past the next rising edge; inputs changed afterwards belong
    // to the following cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic        m_valid, m_hv;
    logic [31:0] m_instr, m_alu, m_hd;

    task automatic model_reset();
        m_valid = 0; m_instr = 0; m_alu = 0; m_hv = 0; m_hd = 0;
    endtask

    function automatic bit op_is_load(input logic [5:0] op);
        return op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25;
    endfunction

    // Edge behaviour, using the inputs present at the edge.
    task automatic model_edge();
        if (flush || !stall) m_hv = 0;
        else if (m_valid && op_is_load(m_instr[31:26]) && !m_hv) begin
            m_hv = 1;
            m_hd = mem_read_data;
        end
        if (flush) m_valid = 0;
        else if (!stall) begin
            m_valid = in_valid;
            m_instr = in_instruction;
            m_alu   = in_alu_result;
        end
    endtask

    task automatic model_out(output logic e_we, output logic [4:0] e_reg,
                             output logic [31:0] e_data, output logic e_mis);
        int          op, a, sh;
        bit          wr;
        int          dst;
        logic [31:0] src, val;
        op  = int'(m_instr[31:26]);
        a   = int'(m_alu[1:0]);
        src = m_hv ? m_hd : mem_read_data;
        wr  = 0; dst = 0; val = m_alu; e_mis = 0;
        if (op == 0) begin
            wr = (m_instr[5:0] != 6'd8); dst = int'(m_instr[15:11]);
        end else if (op >= 8 && op <= 15) begin
            wr = 1; dst = int'(m_instr[20:16]);
        end else if (op == 3) begin
            wr = 1; dst = 31;
        end else if (op_is_load(m_instr[31:26])) begin
            wr = 1; dst = int'(m_instr[20:16]);
            if (op == 32 || op == 36) begin
                sh  = 8 * (3 - a);
                val = (src >> sh) & 32'hFF;
                if (op == 32 && val[7]) val = val | 32'hFFFF_FF00;
            end else if (op == 33 || op == 37) begin
                sh    = (a >= 2) ? 0 : 16;
                val   = (src >> sh) & 32'hFFFF;
                if (op == 33 && val[15]) val = val | 32'hFFFF_0000;
                e_mis = (a % 2) == 1;
            end else begin
                val   = src;
                e_mis = (a != 0);
            end
        end
        e_we   = m_valid && wr && dst != 0 && !stall;
        e_reg  = (m_valid && wr) ? 5'(dst) : 5'd0;
        e_data = (m_valid && wr) ? val : 32'd0;
        e_mis  = m_valid && e_mis;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1;
        drive(0, 0, 0, 0, 0);
        mem_read_data = 32'hDEAD_BEEF;
        #3;
        n_tests++;
        if ({wb_valid, wb_reg_write, wb_write_reg, wb_write_data, wb_misaligned} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_initial: got v=%b we=%b reg=%0d data=%h, required all 0",
                     wb_valid, wb_reg_write, wb_write_reg, wb_write_data);
        end
        #10; reset = 0;
        tick();
        // Capture a live add, then assert reset mid-operation.
        drive(1, r_type(5'd5, 6'h20), 32'h7, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (wb_reg_write !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preop_write: got %b required 1", wb_reg_write);
        end
        reset = 1;
        #1;
        n_tests++;
        if ({wb_valid, wb_reg_write, wb_write_reg, wb_write_data, wb_misaligned} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_midop: got v=%b we=%b reg=%0d data=%h, required all 0",
                     wb_valid, wb_reg_write, wb_write_reg, wb_write_data);
        end
        @(negedge clk); reset = 0;
        tick(); #2;
        n_tests++;
        if (wb_reg_write !== 1'b0 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after_release: got v=%b we=%b required 0 0", wb_valid, wb_reg_write);
        end
    endtask

    task automatic test_alu_write();
        drive(1, r_type(5'd5, 6'h21), 32'h0000_0007, 0, 0);
        tick();
        drive(1, r_type(5'd0, 6'h21), 32'h0000_0009, 0, 0);
        #2;
        n_tests++;
        if (wb_reg_write !== 1'b1 || wb_write_reg !== 5'd5 || wb_write_data !== 32'h7) begin
            n_fail++;
            $display("FAIL alu_rd5: got we=%b reg=%0d data=%h required 1 5 00000007",
                     wb_reg_write, wb_write_reg, wb_write_data);
        end
        tick();
        drive(1, i_type(6'h0D, 5'd9, 16'h1234), 32'hCAFE_0001, 0, 0);
        #2;
        n_tests++;
        if (wb_reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_rd0: got we=%b required 0", wb_reg_write);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        #2;
        n_tests++;
        if (wb_reg_write !== 1'b1 || wb_write_reg !== 5'd9 || wb_write_data !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL alu_ori_rt: got we=%b reg=%0d data=%h required 1 9 cafe0001",
                     wb_reg_write, wb_write_reg, wb_write_data);
        end
    endtask

    task automatic test_load_align();
        logic [5:0]  ops [7] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h23, 6'h25};
        logic [1:0]  adr [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1};
        logic [31:0] exp [7] = '{32'hFFFF_FF81, 32'h0000_0082, 32'hFFFF_F3F4, 32'h0000_8182,
                                 32'h8182_F3F4, 32'h8182_F3F4, 32'h0000_8182};
        logic        mis [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            drive(1, i_type(ops[i], 5'd8, 16'h0), {28'h0000_010, 2'b00, adr[i]}, 0, 0);
            tick();
            drive(0, 0, 0, 0, 0);
            mem_read_data = 32'h8182_F3F4;
            #2;
            n_tests++;
            if (wb_reg_write !== 1'b1 || wb_write_reg !== 5'd8 || wb_write_data !== exp[i]
                || wb_misaligned !== mis[i]) begin
                n_fail++;
                $display("FAIL load_align[%0d] op=%h a=%0d: got we=%b reg=%0d data=%h mis=%b required 1 8 %h %b",
                         i, ops[i], adr[i], wb_reg_write, wb_write_reg, wb_write_data,
                         wb_misaligned, exp[i], mis[i]);
            end
            mem_read_data = 32'h0;
        end
    endtask

    task automatic test_stall_load();
        drive(1, i_type(6'h23, 5'd7, 16'h0200), 32'h0000_0200, 0, 0);
        tick();
        drive(1, r_type(5'd4, 6'h20), 32'h1111_1111, 1, 0);
        mem_read_data = 32'hAAAA_AAAA;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_tests++;
            if (wb_reg_write !== 1'b0 || wb_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_no_write[%0d]: got we=%b v=%b required 0 1", c, wb_reg_write, wb_valid);
            end
            tick();
            mem_read_data = 32'h5555_5555;
        end
        stall = 0;
        #2;
        n_tests++;
        if (wb_reg_write !== 1'b1 || wb_write_reg !== 5'd7 || wb_write_data !== 32'hAAAA_AAAA) begin
            n_fail++;
            $display("FAIL stall_release: got we=%b reg=%0d data=%h required 1 7 aaaaaaaa",
                     wb_reg_write, wb_write_reg, wb_write_data);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        #2;
        n_tests++;
        if (wb_write_reg !== 5'd4 || wb_write_data !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL stall_next_slot: got reg=%0d data=%h required 4 11111111",
                     wb_write_reg, wb_write_data);
        end
    endtask

    task automatic test_flush_stall();
        drive(1, r_type(5'd3, 6'h20), 32'h33, 1, 1);
        tick();
        drive(1, i_type(6'h2B, 5'd6, 16'h0010), 32'h0000_0010, 0, 0);
        #2;
        n_tests++;
        if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: got v=%b we=%b required 0 0", wb_valid, wb_reg_write);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        #2;
        n_tests++;
        if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_write_reg !== 5'd0 || wb_write_data !== 32'd0) begin
            n_fail++;
            $display("FAIL store_no_write: got v=%b we=%b reg=%0d data=%h required 1 0 0 0",
                     wb_valid, wb_reg_write, wb_write_reg, wb_write_data);
        end
    endtask

    task automatic test_jal_jr();
        drive(1, {6'h03, 26'h010_0002}, 32'h0040_0008, 0, 0);
        tick();
        drive(1, r_type(5'd0, 6'h08), 32'h0040_1000, 0, 0);
        #2;
        n_tests++;
        if (wb_reg_write !== 1'b1 || wb_write_reg !== 5'd31 || wb_write_data !== 32'h0040_0008) begin
            n_fail++;
            $display("FAIL jal: got we=%b reg=%0d data=%h required 1 31 00400008",
                     wb_reg_write, wb_write_reg, wb_write_data);
        end
        tick();
        drive(0, 0, 0, 0, 0);
        #2;
        n_tests++;
        if (wb_reg_write !== 1'b0 || wb_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL jr: got we=%b v=%b required 0 1", wb_reg_write, wb_valid);
        end
    endtask

    task automatic test_random();
        logic [5:0]  pool [16] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0F, 6'h03,
                                   6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2B, 6'h04, 6'h02};
        logic        e_we, e_mis;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic [31:0] ins;
        drive(0, 0, 0, 0, 0);
        mem_read_data = 0;
        reset = 1; #2; reset = 0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            ins = $urandom;
            ins[31:26] = pool[$urandom_range(15)];
            if (ins[31:26] == 6'h00 && $urandom_range(3) == 0) ins[5:0] = 6'h08;
            if ($urandom_range(5) == 0) ins[20:16] = 5'd0;
            drive(1'($urandom_range(7) != 0), ins, $urandom,
                  1'($urandom_range(9) < 3), 1'($urandom_range(11) == 0));
            mem_read_data = $urandom;
            #2;
            model_out(e_we, e_reg, e_data, e_mis);
            n_tests++;
            if (wb_valid !== m_valid || wb_reg_write !== e_we || wb_write_reg !== e_reg
                || wb_write_data !== e_data || wb_misaligned !== e_mis) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b we=%b reg=%0d data=%h mis=%b required %b %b %0d %h %b",
                         c, wb_valid, wb_reg_write, wb_write_reg, wb_write_data, wb_misaligned,
                         m_valid, e_we, e_reg, e_data, e_mis);
            end
        end
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_align();
        test_stall_load();
        test_flush_stall();
        test_jal_jr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
